score_display: RTL and testbench

SCORE_DISPLAY -- requirements
Module: score_display

---
 rtl/score_display.sv | 147 ++++++++++++++
 tb/tb_score_display.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/score_display.sv
// Binary score -> 4-digit BCD (double dabble) -> blanked 7-seg; optional game-over blink via SCORE_DISPLAY_BLINK_EN.
// Latency: bcd/valid 12 clocks after the capturing edge, HEX one clock later (13).
// No backpressure: source changes during a conversion are picked up by the next IDLE compare.
module score_display #(
    parameter int BLINK_DIV = 25000000
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [10:0] totalscore,
    input  logic        ready,
    input  logic        lost,
    output logic [15:0] bcd,
    output logic [6:0]  HEX0,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX3,
    output logic        busy,
    output logic        valid
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state;
    logic [26:0] sr;
    logic [3:0]  shift_cnt;
    logic [10:0] last_val;
    logic [15:0] adj;
    logic        blink_on;

    // Add-3 correction on every BCD nibble before each shift
    always_comb begin
        adj = sr[26:11];
        for (int i = 0; i < 4; i++) begin
            if (sr[11+4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = sr[11+4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= IDLE;
            sr        <= '0;
            shift_cnt <= '0;
            last_val  <= '0;
            bcd       <= '0;
            busy      <= 1'b0;
            valid     <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (totalscore != last_val || ready) begin
                        sr        <= {16'h0000, totalscore};
                        last_val  <= totalscore;
                        shift_cnt <= '0;
                        busy      <= 1'b1;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    sr        <= {adj, sr[10:0]} << 1;
                    shift_cnt <= shift_cnt + 4'd1;
                    if (shift_cnt == 4'd10)
                        state <= DONE;
                end
                DONE: begin
                    bcd   <= sr[26:11];
                    valid <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef SCORE_DISPLAY_BLINK_EN
    localparam int CW = $clog2(BLINK_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(BLINK_DIV - 1);

    logic [CW-1:0] blink_cnt;

    // Counter parks at zero with display on whenever the game is live
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (!lost) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (blink_cnt == CNT_MAX) begin
            blink_cnt <= '0;
            blink_on  <= ~blink_on;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end
`else
    logic unused_lost;
    assign unused_lost = lost & (BLINK_DIV >= 2);
    assign blink_on    = 1'b1;
`endif

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    logic blank3, blank2, blank1;
    assign blank3 = (bcd[15:12] == 4'd0);
    assign blank2 = blank3 && (bcd[11:8] == 4'd0);
    assign blank1 = blank2 && (bcd[7:4] == 4'd0);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            HEX0 <= 7'h40;
            HEX1 <= 7'h7F;
            HEX2 <= 7'h7F;
            HEX3 <= 7'h7F;
        end else if (!blink_on) begin
            HEX0 <= 7'h7F;
            HEX1 <= 7'h7F;
            HEX2 <= 7'h7F;
            HEX3 <= 7'h7F;
        end else begin
            HEX0 <= seg7(bcd[3:0]);
            HEX1 <= blank1 ? 7'h7F : seg7(bcd[7:4]);
            HEX2 <= blank2 ? 7'h7F : seg7(bcd[11:8]);
            HEX3 <= blank3 ? 7'h7F : seg7(bcd[15:12]);
        end
    end

endmodule

// File: tb/tb_score_display.sv
// Directed bench for score_display: reset, conversions, retrigger, ready, mid-conversion reset, lost handling.
module tb_score_display;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic [10:0] totalscore;
    logic        ready;
    logic        lost;
    logic [15:0] bcd;
    logic [6:0]  HEX0, HEX1, HEX2, HEX3;
    logic        busy;
    logic        valid;

    int total = 0;
    int bad   = 0;

    score_display #(.BLINK_DIV(4)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .totalscore(totalscore), .ready(ready), .lost(lost),
        .bcd(bcd), .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3),
        .busy(busy), .valid(valid)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] hexes();
        return {4'h0, HEX3, HEX2, HEX1, HEX0};
    endfunction

    function automatic logic [31:0] hx(input logic [6:0] h3, h2, h1, h0);
        return {4'h0, h3, h2, h1, h0};
    endfunction

    // Count busy/valid over n cycles; record bcd at first and last valid
    task automatic watch(input int n, output int nb, output int nv,
                         output logic [15:0] fb, output logic [15:0] lb);
        nb = 0; nv = 0; fb = 16'hFFFF; lb = 16'hFFFF;
        repeat (n) begin
            @(negedge Clk);
            if (busy) nb++;
            if (valid) begin
                if (nv == 0) fb = bcd;
                lb = bcd;
                nv++;
            end
        end
    endtask

    int          nb, nv;
    logic [15:0] fb, lb;
    logic [10:0] vin  [3] = '{11'd1234, 11'd10, 11'd1000};
    logic [15:0] vbcd [3] = '{16'h1234, 16'h0010, 16'h1000};
    logic [31:0] vhex [3];

    initial begin
        vhex[0] = hx(7'h79, 7'h24, 7'h30, 7'h19);
        vhex[1] = hx(7'h7F, 7'h7F, 7'h79, 7'h40);
        vhex[2] = hx(7'h79, 7'h40, 7'h40, 7'h40);

        Reset_n = 1'b0; totalscore = '0; ready = 1'b0; lost = 1'b0;
        repeat (3) @(negedge Clk);
        chk("reset_hex",   hexes(), hx(7'h7F, 7'h7F, 7'h7F, 7'h40));
        chk("reset_bcd",   bcd, 0);
        chk("reset_busy",  busy, 0);
        chk("reset_valid", valid, 0);
        Reset_n = 1'b1;
        watch(20, nb, nv, fb, lb);
        chk("post_reset_no_valid", nv, 0);

        totalscore = 11'd3;
        watch(20, nb, nv, fb, lb);
        chk("s3_busy_cycles", nb, 12);
        chk("s3_valid_count", nv, 1);
        chk("s3_bcd",         lb, 16'h0003);
        chk("s3_hex",         hexes(), hx(7'h7F, 7'h7F, 7'h7F, 7'h30));

        totalscore = 11'd2047;
        watch(20, nb, nv, fb, lb);
        chk("s2047_bcd", lb, 16'h2047);
        chk("s2047_hex", hexes(), hx(7'h24, 7'h40, 7'h19, 7'h78));

        for (int i = 0; i < 3; i++) begin
            totalscore = vin[i];
            watch(20, nb, nv, fb, lb);
            chk("vec_valid", nv, 1);
            chk("vec_bcd",   bcd, {16'h0, vbcd[i]});
            chk("vec_hex",   hexes(), vhex[i]);
        end

        // Score changes mid-conversion: old value finishes, new one follows
        totalscore = 11'd1;
        watch(5, nb, nv, fb, lb);
        chk("retrig_no_early_valid", nv, 0);
        totalscore = 11'd2;
        watch(40, nb, nv, fb, lb);
        chk("retrig_valid_count", nv, 2);
        chk("retrig_first_bcd",   fb, 16'h0001);
        chk("retrig_last_bcd",    lb, 16'h0002);
        chk("retrig_hex", hexes(), hx(7'h7F, 7'h7F, 7'h7F, 7'h24));

        totalscore = 11'd3;
        watch(20, nb, nv, fb, lb);
        watch(20, nb, nv, fb, lb);
        chk("steady_no_valid", nv, 0);
        ready = 1'b1;
        @(negedge Clk);
        ready = 1'b0;
        watch(20, nb, nv, fb, lb);
        chk("ready_valid_count", nv, 1);
        chk("ready_bcd", lb, 16'h0003);
        chk("ready_hex", hexes(), hx(7'h7F, 7'h7F, 7'h7F, 7'h30));

        totalscore = 11'd500;
        watch(4, nb, nv, fb, lb);
        Reset_n = 1'b0;
        #1;
        chk("midrst_busy",  busy, 0);
        chk("midrst_valid", valid, 0);
        chk("midrst_bcd",   bcd, 0);
        chk("midrst_hex",   hexes(), hx(7'h7F, 7'h7F, 7'h7F, 7'h40));
        @(negedge Clk);
        Reset_n = 1'b1;
        watch(20, nb, nv, fb, lb);
        chk("midrst_reconv_valid", nv, 1);
        chk("midrst_reconv_bcd",   lb, 16'h0500);
        chk("midrst_reconv_hex",   hexes(), hx(7'h7F, 7'h12, 7'h40, 7'h40));

`ifdef SCORE_DISPLAY_BLINK_EN
        lost = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge Clk);
            chk("blink_phase", hexes(),
                ((k % 8) < 4) ? hx(7'h7F, 7'h12, 7'h40, 7'h40) : hx(7'h7F, 7'h7F, 7'h7F, 7'h7F));
        end
        lost = 1'b0;
        repeat (2) @(negedge Clk);
        chk("blink_restore", hexes(), hx(7'h7F, 7'h12, 7'h40, 7'h40));
        chk("blink_bcd_kept", bcd, 16'h0500);
`else
        lost = 1'b1;
        watch(20, nb, nv, fb, lb);
        chk("lost_ignored_hex",   hexes(), hx(7'h7F, 7'h12, 7'h40, 7'h40));
        chk("lost_ignored_valid", nv, 0);
        lost = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
